instr_fetch_queue: RTL and testbench

Instruction fetch front end placed directly upstream of the MIPS datapath. It owns the program counter, issues sequential reads to the synchronous program memory and buffers the returned instructions, each with its PC and PC+4, in a small FIFO. The decode/execute stage consumes them through a valid/ready handshake. A redirect from the execute stage (branch, j, jal, jr) flushes the queue, discards any in-flight read and restarts fetching at the target.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 96 +++++++++
 tb/tb_instr_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants and the queue entry type for the MIPS instruction fetch front end.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0040_0000;
  localparam int          PC_INCREMENT_DEFAULT = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two; the count carries one
// extra bit so that a full queue is distinguishable from an empty one.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_push_data,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Pointer and count bookkeeping; a flush empties the queue like a reset does.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = !w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues sequential reads to a
// 1-cycle-latency program memory, tracks the single outstanding read and buffers
// returned instructions for the decode stage. A redirect flushes everything and
// restarts fetching at the target.
module instr_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int          PC_INCREMENT = PC_INCREMENT_DEFAULT,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  localparam int         CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic [CNT_W-1:0] occupancy
);

  localparam int SUM_W = CNT_W + 1;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight_v;

  logic [CNT_W-1:0] w_count;
  logic [SUM_W-1:0] w_credits_used;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;
  logic [1:0]       w_unused_pc_bits;

  assign w_unused_pc_bits = redirect_pc[1:0];

  // Every queued entry plus the read in flight consumes one slot, so issuing only
  // while slots remain means a returning instruction always has room.
  assign w_credits_used = {1'b0, w_count} + SUM_W'(r_inflight_v);
  assign w_issue        = !reset && !redirect && (w_credits_used < SUM_W'(DEPTH));

  // A returning read is discarded if a redirect lands in the same cycle.
  assign w_push      = r_inflight_v && !redirect && !reset;
  assign w_push_data = '{instr: imem_rdata, pc: r_inflight_pc};
  assign w_pop       = w_head_valid && out_ready && !reset;

  // Program counter and in-flight tracker; reset beats redirect, redirect beats issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
      r_inflight_v <= 1'b0;
    end else begin
      r_inflight_v <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'(PC_INCREMENT);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .i_push_data(w_push_data),
    .o_head     (w_head),
    .o_valid    (w_head_valid),
    .o_count    (w_count)
  );

  assign imem_req     = w_issue;
  assign imem_addr    = r_fetch_pc;
  assign out_valid    = w_head_valid;
  assign out_instr    = w_head.instr;
  assign out_pc       = w_head.pc;
  assign out_pc_plus4 = w_head_valid ? (w_head.pc + 32'(PC_INCREMENT)) : '0;
  assign occupancy    = w_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a hand-derived vector table, a few
// multi-cycle corner sequences and a randomized run against a queue-based model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = '0;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic [31:0] outPcPlus4;
  logic [2:0]  occupancy;

  int passCount  = 0;
  int checkCount = 0;

  // Reference model: the list of PCs the consumer will see, plus the pending read.
  logic [31:0] modelQ[$];
  logic        modelInfl;
  logic [31:0] modelInflPc;
  logic [31:0] modelFetchPc;

  typedef struct {
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        eValid;
    logic [31:0] ePc;
    logic [2:0]  eOcc;
    logic        eReq;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vecs[14];

  instr_fetch_queue #(
    .DEPTH       (DEPTH),
    .PC_INCREMENT(4),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imemReq),
    .imem_addr   (imemAddr),
    .imem_rdata  (imemRdata),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_instr   (outInstr),
    .out_pc      (outPc),
    .out_pc_plus4(outPcPlus4),
    .occupancy   (occupancy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Program memory with one cycle of read latency; each word encodes its address.
  always @(posedge clk) imemRdata <= imemAddr ^ MEM_KEY;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
  endfunction

  function automatic vec_t mkVec(logic rdr, logic [31:0] rpc, logic rdy, logic eValid,
                                 logic [31:0] ePc, logic [2:0] eOcc, logic eReq,
                                 logic [31:0] eAddr);
    vec_t v;
    v.rdr = rdr; v.rpc = rpc; v.rdy = rdy; v.eValid = eValid;
    v.ePc = ePc; v.eOcc = eOcc; v.eReq = eReq; v.eAddr = eAddr;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc,
                               input logic rdy);
    reset      = rst;
    redirect   = rdr;
    redirectPc = rpc;
    outReady   = rdy;
    #1;
  endtask

  task automatic checkOutput(input logic eValid, input logic [31:0] ePc, input logic [2:0] eOcc,
                             input logic eReq, input logic [31:0] eAddr);
    compare("out_valid", 32'(outValid), 32'(eValid));
    compare("out_pc", outPc, eValid ? ePc : 32'h0);
    compare("out_instr", outInstr, eValid ? (ePc ^ MEM_KEY) : 32'h0);
    compare("out_pc_plus4", outPcPlus4, eValid ? (ePc + 32'd4) : 32'h0);
    compare("occupancy", 32'(occupancy), 32'(eOcc));
    compare("imem_req", 32'(imemReq), 32'(eReq));
    compare("imem_addr", imemAddr, eAddr);
  endtask

  function automatic logic modelReq();
    return !reset && !redirect && ((modelQ.size() + int'(modelInfl)) < DEPTH);
  endfunction

  task automatic checkModel();
    logic ev;
    ev = (modelQ.size() > 0);
    checkOutput(ev, ev ? modelQ[0] : 32'h0, 3'(modelQ.size()), modelReq(), modelFetchPc);
  endtask

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the same edge and park on the falling edge.
  task automatic clockStep();
    logic req;
    req = modelReq();
    if (reset) begin
      modelQ.delete();
      modelInfl    = 1'b0;
      modelFetchPc = RESET_PC;
    end else if (redirect) begin
      modelQ.delete();
      modelInfl    = 1'b0;
      modelFetchPc = {redirectPc[31:2], 2'b00};
    end else begin
      if (modelQ.size() > 0 && outReady) void'(modelQ.pop_front());
      if (modelInfl) modelQ.push_back(modelInflPc);
      modelInfl = req;
      if (req) begin
        modelInflPc  = modelFetchPc;
        modelFetchPc = modelFetchPc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        seen;
    int          got;
    logic [31:0] wrapPcs[3];

    // Stall, fill, credit return and a redirect while three entries are queued
    // and a read is in flight.
    vecs[0]  = mkVec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 1'b1, 32'h0040_0000);
    vecs[1]  = mkVec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 1'b1, 32'h0040_0004);
    vecs[2]  = mkVec(1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0000, 3'd1, 1'b1, 32'h0040_0008);
    vecs[3]  = mkVec(1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0004, 3'd1, 1'b1, 32'h0040_000C);
    vecs[4]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008, 3'd1, 1'b1, 32'h0040_0010);
    vecs[5]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008, 3'd2, 1'b1, 32'h0040_0014);
    vecs[6]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008, 3'd3, 1'b0, 32'h0040_0018);
    vecs[7]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008, 3'd4, 1'b0, 32'h0040_0018);
    vecs[8]  = mkVec(1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0008, 3'd4, 1'b0, 32'h0040_0018);
    vecs[9]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_000C, 3'd3, 1'b1, 32'h0040_0018);
    vecs[10] = mkVec(1'b1, 32'h0040_0103, 1'b0, 1'b1, 32'h0040_000C, 3'd3, 1'b0, 32'h0040_001C);
    vecs[11] = mkVec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 1'b1, 32'h0040_0100);
    vecs[12] = mkVec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0, 1'b1, 32'h0040_0104);
    vecs[13] = mkVec(1'b0, 32'h0,         1'b1, 1'b1, 32'h0040_0100, 3'd1, 1'b1, 32'h0040_0108);

    reset = 1'b1; redirect = 1'b0; redirectPc = '0; outReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    modelQ.delete();
    modelInfl    = 1'b0;
    modelInflPc  = '0;
    modelFetchPc = RESET_PC;
    $display("[TB] reset released, starting vector table");

    // Reset state while reset is still held: nothing queued, no request.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput(1'b0, 32'h0, 3'd0, 1'b0, RESET_PC);
    clockStep();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
      checkOutput(vecs[i].eValid, vecs[i].ePc, vecs[i].eOcc, vecs[i].eReq, vecs[i].eAddr);
      clockStep();
    end

    // Redirect together with a pop, then a second redirect: only 0x40 may appear.
    $display("[TB] back-to-back redirects");
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b1);
    checkModel();
    compare("pop_during_redirect", outPc, 32'h0040_0104);
    clockStep();
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    checkModel();
    clockStep();
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkModel();
      if (outValid) begin
        seen = 1'b1;
        compare("resume_pc", outPc, 32'h0000_0040);
      end
      clockStep();
    end
    compare("resume_seen", 32'(seen), 32'd1);

    // Address wrap past the top of memory.
    $display("[TB] wraparound redirect");
    wrapPcs[0] = 32'hFFFF_FFF8; wrapPcs[1] = 32'hFFFF_FFFC; wrapPcs[2] = 32'h0000_0000;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    checkModel();
    clockStep();
    got = 0;
    for (int i = 0; i < 12 && got < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkModel();
      if (outValid) begin
        compare("wrap_pc", outPc, wrapPcs[got]);
        if (got == 2) compare("wrap_pc_plus4", outPcPlus4, 32'h0000_0004);
        got++;
      end
      clockStep();
    end
    compare("wrap_count", 32'(got), 32'd3);

    // Reset mid-stream with a redirect in the same cycle: reset must win.
    $display("[TB] reset during redirect");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkModel();
      clockStep();
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    checkModel();
    clockStep();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkModel();
    compare("post_reset_valid", 32'(outValid), 32'd0);
    compare("post_reset_occ", 32'(occupancy), 32'd0);
    compare("post_reset_addr", imemAddr, RESET_PC);
    clockStep();

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom,
                    $urandom_range(0, 3) != 0);
      checkModel();
      clockStep();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
